prod_accumulator: RTL and testbench



---
 rtl/prod_accumulator.sv | 150 +++++++++++++++
 tb/tb_prod_accumulator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums one frame of 8-bit unsigned products into an ACC_W-bit
// accumulator and hands the sum, term count and overflow flag downstream.
// A frame closes on an accepted in_last beat or when it reaches 2^CNT_W-1 terms.
// The result is held until acc_valid && acc_ready. After that handshake the
// accumulator clears and the block accepts the next frame.
// Optional build macro PROD_ACC_SAT_EN: on carry-out the sum clamps to
// 2^ACC_W-1 for the rest of the frame. Without it the sum wraps modulo 2^ACC_W.
// acc_ovf is set in both builds.
module prod_accumulator #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_prod,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_sum,
    output logic [CNT_W-1:0] acc_count,
    output logic             acc_ovf,
    output logic             acc_valid,
    input  logic             acc_ready
);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
    logic [CNT_W-1:0] acc_count_q, acc_count_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic             acc_valid_q, acc_valid_d;

    logic [ACC_W:0]   add_full;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] count_next;
    logic             ovf_next;
    logic             beat;
    logic             close;
    logic             res_taken;

    // Post-add values for the current beat and the frame-close decision
    always_comb begin
        add_full   = {1'b0, sum_q} + {{(ACC_W - 7){1'b0}}, in_prod};
        ovf_next   = ovf_q | add_full[ACC_W];
`ifdef PROD_ACC_SAT_EN
        // Once saturated, hold at full scale for the rest of the frame
        sum_next   = ovf_next ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
        sum_next   = add_full[ACC_W-1:0];
`endif
        count_next = count_q + CNT_W'(1);
        close      = in_last || (count_next == CntMax);
        beat       = in_valid && in_ready;
        res_taken  = acc_valid_q && acc_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: close a frame into HOLD, leave HOLD on result handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (beat && close) state_d = StHold;
            StHold:  if (res_taken)     state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    // Output decode: beats are only taken while accumulating
    always_comb begin
        in_ready = (state_q == StAccum);
    end

    // Accumulator and result-register next values
    always_comb begin
        sum_d       = sum_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        acc_sum_d   = acc_sum_q;
        acc_count_d = acc_count_q;
        acc_ovf_d   = acc_ovf_q;
        acc_valid_d = acc_valid_q;
        unique case (state_q)
            StAccum: begin
                if (beat) begin
                    sum_d   = sum_next;
                    count_d = count_next;
                    ovf_d   = ovf_next;
                    if (close) begin
                        acc_sum_d   = sum_next;
                        acc_count_d = count_next;
                        acc_ovf_d   = ovf_next;
                        acc_valid_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (res_taken) begin
                    sum_d       = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                    acc_valid_d = 1'b0;
                end
            end
            default: begin
                acc_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset discards any partial frame or held result
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            acc_sum_q   <= '0;
            acc_count_q <= '0;
            acc_ovf_q   <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            acc_sum_q   <= acc_sum_d;
            acc_count_q <= acc_count_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign acc_sum   = acc_sum_q;
    assign acc_count = acc_count_q;
    assign acc_ovf   = acc_ovf_q;
    assign acc_valid = acc_valid_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator. Two instances share all stimulus: one at
// ACC_W=16 and one at ACC_W=9. The handshake is width-independent, so both
// instances see the same accept/hold sequence. Only the sums and overflow
// flags differ. Expected results come from plain integer frame totals.
module tb_prod_accumulator;

    logic       clk;
    logic       rst;
    logic [7:0] in_prod;
    logic       in_valid;
    logic       in_last;
    logic       acc_ready;

    logic        a_in_ready, a_acc_ovf, a_acc_valid;
    logic [15:0] a_acc_sum;
    logic [4:0]  a_acc_count;
    logic        b_in_ready, b_acc_ovf, b_acc_valid;
    logic [8:0]  b_acc_sum;
    logic [4:0]  b_acc_count;

    int checks = 0;
    int errors = 0;

    prod_accumulator #(.ACC_W(16), .CNT_W(5)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (a_in_ready),
        .acc_sum   (a_acc_sum),
        .acc_count (a_acc_count),
        .acc_ovf   (a_acc_ovf),
        .acc_valid (a_acc_valid),
        .acc_ready (acc_ready)
    );

    prod_accumulator #(.ACC_W(9), .CNT_W(5)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (b_in_ready),
        .acc_sum   (b_acc_sum),
        .acc_count (b_acc_count),
        .acc_ovf   (b_acc_ovf),
        .acc_valid (b_acc_valid),
        .acc_ready (acc_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Frame result from the arithmetic total of its products
    function automatic void ref_res(input longint tot, input int w,
                                    output int unsigned s, output int unsigned o);
        longint lim;
        lim = (longint'(1) << w) - 1;
        if (tot > lim) begin
            o = 1;
`ifdef PROD_ACC_SAT_EN
            s = int'(lim);
`else
            s = int'(tot % (lim + 1));
`endif
        end else begin
            o = 0;
            s = int'(tot);
        end
    endfunction

    task automatic chk_res(input string tag, input longint tot, input int cnt);
        int unsigned s, o;
        chk({tag, "_valid_a"}, a_acc_valid, 1);
        chk({tag, "_valid_b"}, b_acc_valid, 1);
        ref_res(tot, 16, s, o);
        chk({tag, "_sum_a"}, a_acc_sum, s);
        chk({tag, "_ovf_a"}, a_acc_ovf, o);
        chk({tag, "_cnt_a"}, a_acc_count, cnt);
        ref_res(tot, 9, s, o);
        chk({tag, "_sum_b"}, b_acc_sum, s);
        chk({tag, "_ovf_b"}, b_acc_ovf, o);
        chk({tag, "_cnt_b"}, b_acc_count, cnt);
    endtask

    longint tot_q[$];
    int     cnt_q[$];
    longint cur_tot;
    int     cur_cnt;
    logic       pend_valid;
    logic [7:0] pend_prod;
    logic       pend_last;
    int         drain;

    initial begin
        rst = 1'b1; in_prod = '0; in_valid = 1'b0; in_last = 1'b0; acc_ready = 1'b0;
        @(negedge clk);
        tick(); tick();
        // Reset values
        chk("rst_valid", a_acc_valid, 0);
        chk("rst_sum", a_acc_sum, 0);
        chk("rst_cnt", a_acc_count, 0);
        chk("rst_ovf", a_acc_ovf, 0);
        rst = 1'b0;
        tick();
        chk("rst_ready", a_in_ready, 1);

        // 1: frame 3,5,7
        in_valid = 1'b1; in_prod = 8'd3; tick();
        in_prod = 8'd5; tick();
        in_prod = 8'd7; in_last = 1'b1; acc_ready = 1'b1;
        chk("t1_ready_last", a_in_ready, 1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk_res("t1", 15, 3);
        chk("t1_busy", a_in_ready, 0);
        tick();
        chk("t1_ready_again", a_in_ready, 1);
        chk("t1_valid_clr", a_acc_valid, 0);

        // 2: back-pressure with the next beat held upstream
        acc_ready = 1'b0; in_valid = 1'b1; in_prod = 8'd225; in_last = 1'b1;
        tick();
        in_prod = 8'd9;
        for (int i = 0; i < 4; i++) begin
            chk("t2_ready_low", a_in_ready, 0);
            chk_res("t2_hold", 225, 1);
            tick();
        end
        acc_ready = 1'b1;
        chk_res("t2_pre_hs", 225, 1);
        tick();
        chk("t2_ready_hs", a_in_ready, 1);
        chk("t2_valid_hs", a_acc_valid, 0);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk_res("t2_next", 9, 1);
        tick();

        // 3: forced close after 31 terms
        acc_ready = 1'b0; in_valid = 1'b1; in_prod = 8'd1; in_last = 1'b0;
        for (int i = 0; i < 31; i++) begin
            chk("t3_ready", a_in_ready, 1);
            tick();
        end
        chk_res("t3", 31, 31);
        chk("t3_busy", a_in_ready, 0);
        acc_ready = 1'b1; in_prod = 8'd2; in_last = 1'b1;
        tick();
        chk("t3_ready_again", a_in_ready, 1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk_res("t3_next", 2, 1);
        tick();

        // 4: overflow on the 9-bit instance
        in_valid = 1'b1; in_prod = 8'd255; tick();
        tick();
        in_prod = 8'd10; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk_res("t4", 520, 3);
`ifdef PROD_ACC_SAT_EN
        chk("t4_sum_b_lit", b_acc_sum, 511);
`else
        chk("t4_sum_b_lit", b_acc_sum, 8);
`endif
        chk("t4_ovf_b_lit", b_acc_ovf, 1);
        tick();

        // 5: reset mid-frame discards the partial sum
        in_valid = 1'b1; in_prod = 8'd100; tick();
        tick();
        in_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("t5_valid", a_acc_valid, 0);
        chk("t5_ready", a_in_ready, 1);
        in_valid = 1'b1; in_prod = 8'd4; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk_res("t5", 4, 1);
        tick();

        // 6: random stream against a frame scoreboard
        cur_tot = 0; cur_cnt = 0; pend_valid = 1'b0; pend_prod = '0; pend_last = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!pend_valid && $urandom_range(0, 3) != 0) begin
                pend_valid = 1'b1;
                pend_prod  = 8'($urandom_range(0, 255));
                pend_last  = ($urandom_range(0, 7) == 0);
            end
            in_valid  = pend_valid;
            in_prod   = pend_valid ? pend_prod : 8'($urandom_range(0, 255));
            in_last   = pend_valid ? pend_last : 1'($urandom_range(0, 1));
            acc_ready = ($urandom_range(0, 2) != 0);
            chk("t6_ready", a_in_ready, (tot_q.size() == 0) ? 1 : 0);
            chk("t6_valid", b_acc_valid, (tot_q.size() != 0) ? 1 : 0);
            if (a_acc_valid && acc_ready && tot_q.size() != 0) begin
                chk_res("t6_res", tot_q.pop_front(), cnt_q.pop_front());
            end
            if (in_valid && a_in_ready) begin
                cur_tot += longint'(in_prod);
                cur_cnt++;
                if (in_last || cur_cnt == 31) begin
                    tot_q.push_back(cur_tot);
                    cnt_q.push_back(cur_cnt);
                    cur_tot = 0;
                    cur_cnt = 0;
                end
                pend_valid = 1'b0;
            end
            tick();
        end

        // Drain any outstanding result within a bounded number of cycles
        in_valid = 1'b0; in_last = 1'b0; acc_ready = 1'b1;
        drain = 0;
        while (tot_q.size() != 0 && drain < 8) begin
            if (a_acc_valid) chk_res("t6_drain", tot_q.pop_front(), cnt_q.pop_front());
            tick();
            drain++;
        end
        chk("t6_drained", tot_q.size(), 0);
        chk("t6_idle_valid", a_acc_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
